// File: rtl/fibo_pkg.sv
// rtl/fibo_pkg.sv - shared ALU opcodes, state encoding and seed value for the Fibonacci engine
package fibo_pkg;

  localparam logic [2:0] ALU_PASS   = 3'b001;
  localparam logic [2:0] ALU_ADD    = 3'b110;
  localparam int         SEED_VALUE = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEED0 = 3'd1,
    SEED3 = 3'd2,
    ADD   = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/fibo_controller.sv
// rtl/fibo_controller.sv - control FSM sequencing seed writes and rotating ADD steps for the Fibonacci datapath
module fibo_controller
  import fibo_pkg::*;
#(
  parameter int size = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [size-1:0] n,
  output logic            busy,
  output logic            done,
  output logic [1:0]      wrt_addr,
  output logic            wrt_en,
  output logic            load_data,
  output logic [1:0]      rd_addr1,
  output logic [1:0]      rd_addr2,
  output logic [2:0]      alu_opcode,
  output logic [size-1:0] count
);

  localparam logic [size-1:0] ONE  = size'(1);
  localparam logic [size-1:0] SEED = size'(SEED_VALUE);

  state_t          state, state_nxt;
  logic [1:0]      ptr;
  logic [1:0]      res_addr;
  logic [size-1:0] iter;
  logic [size-1:0] n_r;
  logic            last_add;

  assign last_add = (iter == n_r - ONE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      iter     <= '0;
      n_r      <= '0;
      res_addr <= 2'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            n_r  <= n;
            ptr  <= 2'd0;
            iter <= '0;
          end
        end
        SEED3: begin
          if (n_r == '0) res_addr <= ptr;
        end
        ADD: begin
          ptr  <= ptr + 2'd1;
          iter <= iter + ONE;
          // res_addr must already hold the last written slot while in DONE
          if (last_add) res_addr <= ptr + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    wrt_en     = 1'b0;
    load_data  = 1'b0;
    wrt_addr   = 2'd0;
    rd_addr1   = res_addr;
    rd_addr2   = res_addr;
    alu_opcode = ALU_PASS;
    count      = '0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = SEED0;
      end
      SEED0: begin
        wrt_en    = 1'b1;
        load_data = 1'b1;
        wrt_addr  = 2'd0;
        count     = SEED;
        rd_addr1  = 2'd0;
        rd_addr2  = 2'd0;
        state_nxt = SEED3;
      end
      SEED3: begin
        wrt_en    = 1'b1;
        load_data = 1'b1;
        wrt_addr  = 2'd3;
        count     = SEED;
        rd_addr1  = 2'd0;
        rd_addr2  = 2'd0;
        state_nxt = (n_r != '0) ? ADD : DONE;
      end
      ADD: begin
        wrt_en     = 1'b1;
        alu_opcode = ALU_ADD;
        wrt_addr   = ptr + 2'd1;
        rd_addr1   = ptr;
        rd_addr2   = ptr - 2'd1;
        state_nxt  = last_add ? DONE : ADD;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fibo_controller.sv
// tb/tb_fibo_controller.sv - bench for fibo_controller with a register-file model and expected-write scoreboard
module tb_fibo_controller;
  import fibo_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] n = 4'd0;
  logic       busy, done, wrt_en, load_data;
  logic [1:0] wrt_addr, rd_addr1, rd_addr2;
  logic [2:0] alu_opcode;
  logic [3:0] count;

  typedef struct {
    logic [1:0] a;
    logic [3:0] d;
  } wr_t;

  wr_t        q[$];
  logic [3:0] rf[4];
  int         total = 0;
  int         bad = 0;

  fibo_controller #(.size(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .n(n),
    .busy(busy), .done(done), .wrt_addr(wrt_addr), .wrt_en(wrt_en),
    .load_data(load_data), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .alu_opcode(alu_opcode), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Expected writes: two seeds, then the first lim Fibonacci ADD results
  task automatic push_exp(input int nv, input int lim);
    logic [3:0] a, b, s;
    q.push_back('{2'd0, 4'd1});
    q.push_back('{2'd3, 4'd1});
    a = 4'd1;
    b = 4'd1;
    for (int i = 0; i < nv && i < lim; i++) begin
      s = a + b;
      q.push_back('{2'((i + 1) % 4), s});
      a = b;
      b = s;
    end
  endtask

  function automatic logic [3:0] fib_final(input int nv);
    logic [3:0] a, b, s;
    a = 4'd1;
    b = 4'd1;
    for (int i = 0; i < nv; i++) begin
      s = a + b;
      a = b;
      b = s;
    end
    return b;
  endfunction

  // Datapath model: commits each write and checks it against the scoreboard
  always @(negedge clk) begin
    logic [3:0] wd;
    wr_t        e;
    if (rst_n && wrt_en) begin
      wd = load_data ? count
         : (alu_opcode == ALU_ADD) ? rf[rd_addr1] + rf[rd_addr2] : rf[rd_addr1];
      if (q.size() == 0) begin
        chk("unexpected_write", 32'(wrt_addr), 32'hFFFF);
      end else begin
        e = q.pop_front();
        chk("wr_addr", 32'(wrt_addr), 32'(e.a));
        chk("wr_data", 32'(wd), 32'(e.d));
      end
      rf[wrt_addr] = wd;
    end
  end

  // Called just after the accepting edge; returns at the negedge of the IDLE cycle after DONE
  task automatic wait_done(input int nv);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 40);
    chk("latency", 32'(k), 32'(3 + nv));
    chk("busy_in_done", 32'(busy), 32'd1);
    chk("wen_in_done", 32'(wrt_en), 32'd0);
    chk("res_addr", 32'(rd_addr1), 32'(nv % 4));
    chk("result", 32'(rf[rd_addr1]), 32'(fib_final(nv)));
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic run(input int nv);
    start = 1'b1;
    n = 4'(nv);
    push_exp(nv, 99);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(nv);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) rf[i] = 4'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_wen", 32'(wrt_en), 32'd0);
    chk("rst_rd1", 32'(rd_addr1), 32'd0);
    chk("rst_alu", 32'(alu_opcode), 32'(ALU_PASS));
    chk("rst_count", 32'(count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run(4);
    run(0);
    run(6);

    // start held high: one run, then a second run with n re-captured in the following IDLE cycle
    start = 1'b1;
    n = 4'd4;
    push_exp(4, 99);
    push_exp(1, 99);
    @(posedge clk);
    #1 n = 4'd1;
    wait_done(4);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(1);

    // asynchronous reset in the middle of the third ADD cycle
    start = 1'b1;
    n = 4'd5;
    push_exp(5, 2);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_wen", 32'(wrt_en), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_res_addr", 32'(rd_addr1), 32'd0);
    chk("mid_rst_alu", 32'(alu_opcode), 32'(ALU_PASS));
    chk("mid_rst_pending", 32'(q.size()), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(3);

    // n changed after capture is ignored
    start = 1'b1;
    n = 4'd2;
    push_exp(2, 99);
    @(posedge clk);
    #1 start = 1'b0;
    n = 4'd9;
    wait_done(2);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
